tdm_demux: RTL and testbench

Registered 1-to-CH time-division demultiplexer, the receive-side counterpart of the team's 2:1 / N:1 multiplexers. It takes one serial word stream in which `sync` marks slot 0, steers each valid word to its channel register, and flags each completed frame. A small HUNT/LOCK state machine handles frame alignment, errors and resynchronisation.

---
 rtl/tdm_demux.sv | 125 ++++++++++++
 tb/tb_tdm_demux.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/tdm_demux.sv
// Registered 1-to-CH TDM demultiplexer with HUNT/LOCK frame alignment.
// Define TDM_DEMUX_FRAME_BUF_EN to present whole frames atomically on dout.
module tdm_demux #(
    parameter int WIDTH = 8,
    parameter int CH    = 4,
    parameter int SW    = $clog2(CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      din,
    input  logic                  din_valid,
    input  logic                  sync,
    output logic [CH*WIDTH-1:0]   dout,
    output logic [CH-1:0]         ch_valid,
    output logic                  frame_done,
    output logic [SW-1:0]         slot,
    output logic                  locked,
    output logic                  err
);

    localparam logic [0:0] HUNT = 1'b0;
    localparam logic [0:0] LOCK = 1'b1;

    logic [0:0]    state_reg, state_next;
    logic [SW-1:0] slot_reg, slot_next;
    logic          err_reg, err_next;
    logic          frame_done_reg, frame_next;
    logic          cap;
    logic [SW-1:0] cap_slot;

    always_comb begin
        state_next = state_reg;
        slot_next  = slot_reg;
        err_next   = 1'b0;
        frame_next = 1'b0;
        cap        = 1'b0;
        cap_slot   = '0;
        if (din_valid) begin
            if (state_reg == HUNT) begin
                if (sync) begin
                    cap        = 1'b1;
                    slot_next  = SW'(1);
                    state_next = LOCK;
                end
            end else if (sync) begin
                // Early sync restarts the frame at slot 0 but keeps lock.
                cap       = 1'b1;
                slot_next = SW'(1);
                err_next  = (slot_reg != '0);
            end else if (slot_reg != '0) begin
                cap        = 1'b1;
                cap_slot   = slot_reg;
                slot_next  = slot_reg + SW'(1);
                frame_next = (slot_reg == SW'(CH - 1));
            end else begin
                err_next   = 1'b1;
                state_next = HUNT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= HUNT;
            slot_reg       <= '0;
            err_reg        <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            slot_reg       <= slot_next;
            err_reg        <= err_next;
            frame_done_reg <= frame_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            logic [WIDTH-1:0] word_reg;
            logic             valid_reg;
            logic             wr_en;

            assign wr_en = cap && (cap_slot == SW'(gi));

`ifdef TDM_DEMUX_FRAME_BUF_EN
            logic [WIDTH-1:0] buf_reg;

            // The last slot's word bypasses the shadow so the frame lands in one edge.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    buf_reg   <= '0;
                    word_reg  <= '0;
                    valid_reg <= 1'b0;
                end else begin
                    if (wr_en)
                        buf_reg <= din;
                    valid_reg <= frame_next;
                    if (frame_next)
                        word_reg <= (gi == CH - 1) ? din : buf_reg;
                end
            end
`else
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    word_reg  <= '0;
                    valid_reg <= 1'b0;
                end else begin
                    valid_reg <= wr_en;
                    if (wr_en)
                        word_reg <= din;
                end
            end
`endif

            assign dout[gi*WIDTH +: WIDTH] = word_reg;
            assign ch_valid[gi]            = valid_reg;
        end
    endgenerate

    assign slot       = slot_reg;
    assign locked     = (state_reg == LOCK);
    assign err        = err_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux (WIDTH=8, CH=4); directed vectors with
// hand-computed results for both the per-slot and frame-buffered builds.
module tb_tdm_demux;

`ifdef TDM_DEMUX_FRAME_BUF_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  din;
    logic        din_valid;
    logic        sync;
    logic [31:0] dout;
    logic [3:0]  ch_valid;
    logic        frame_done;
    logic [1:0]  slot;
    logic        locked;
    logic        err;

    typedef struct packed {
        logic [31:0] dout;
        logic [3:0]  chv;
        logic        fd;
        logic [1:0]  slot;
        logic        lock;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    tdm_demux #(.WIDTH(8), .CH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .sync       (sync),
        .dout       (dout),
        .ch_valid   (ch_valid),
        .frame_done (frame_done),
        .slot       (slot),
        .locked     (locked),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void chk_all(exp_t e, string tag);
        chk({tag, ".dout"},       dout,              e.dout);
        chk({tag, ".ch_valid"},   32'(ch_valid),     32'(e.chv));
        chk({tag, ".frame_done"}, 32'(frame_done),   32'(e.fd));
        chk({tag, ".slot"},       32'(slot),         32'(e.slot));
        chk({tag, ".locked"},     32'(locked),       32'(e.lock));
        chk({tag, ".err"},        32'(err),          32'(e.err));
    endfunction

    // Monitor: every expectation queued before an edge is checked just after it.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            txn++;
            chk_all(e, $sformatf("txn%0d", txn));
            $display("txn %0d: dout=%h ch_valid=%b fd=%b slot=%0d locked=%b err=%b",
                     txn, dout, ch_valid, frame_done, slot, locked, err);
        end
    end

    task automatic step(input logic [7:0] d, input logic v, input logic s,
                        input logic [31:0] ed, input logic [3:0] ec, input logic ef,
                        input logic [1:0] es, input logic el, input logic ee);
        exp_t e;
        @(negedge clk);
        din = d; din_valid = v; sync = s;
        e = '{dout: ed, chv: ec, fd: ef, slot: es, lock: el, err: ee};
        exp_q.push_back(e);
    endtask

    initial begin
        exp_t zero;
        zero = '0;
        rst = 1'b1; din = '0; din_valid = 1'b0; sync = 1'b0;
        #1;
        chk_all(zero, "reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // No sync after reset: words dropped, no error.
        step(8'hAA, 1, 0, 32'h0, 4'h0, 0, 2'd0, 0, 0);
        step(8'hBB, 1, 0, 32'h0, 4'h0, 0, 2'd0, 0, 0);

        // First full frame.
        step(8'h11, 1, 1, BUF ? 32'h0 : 32'h00000011, BUF ? 4'h0 : 4'b0001, 0, 2'd1, 1, 0);
        step(8'h22, 1, 0, BUF ? 32'h0 : 32'h00002211, BUF ? 4'h0 : 4'b0010, 0, 2'd2, 1, 0);
        step(8'h33, 1, 0, BUF ? 32'h0 : 32'h00332211, BUF ? 4'h0 : 4'b0100, 0, 2'd3, 1, 0);
        step(8'h44, 1, 0, 32'h44332211, BUF ? 4'hF : 4'b1000, 1, 2'd0, 1, 0);
        step(8'h00, 0, 0, 32'h44332211, 4'h0, 0, 2'd0, 1, 0);

        // Early sync on the third word, then the restarted frame completes.
        step(8'hA1, 1, 1, BUF ? 32'h44332211 : 32'h443322A1, BUF ? 4'h0 : 4'b0001, 0, 2'd1, 1, 0);
        step(8'hA2, 1, 0, BUF ? 32'h44332211 : 32'h4433A2A1, BUF ? 4'h0 : 4'b0010, 0, 2'd2, 1, 0);
        step(8'h55, 1, 1, BUF ? 32'h44332211 : 32'h4433A255, BUF ? 4'h0 : 4'b0001, 0, 2'd1, 1, 1);
        step(8'hB2, 1, 0, BUF ? 32'h44332211 : 32'h4433B255, BUF ? 4'h0 : 4'b0010, 0, 2'd2, 1, 0);
        step(8'hB3, 1, 0, BUF ? 32'h44332211 : 32'h44B3B255, BUF ? 4'h0 : 4'b0100, 0, 2'd3, 1, 0);
        step(8'hB4, 1, 0, 32'hB4B3B255, BUF ? 4'hF : 4'b1000, 1, 2'd0, 1, 0);

        // Missing sync at slot 0: error, drop, back to HUNT.
        step(8'h66, 1, 0, 32'hB4B3B255, 4'h0, 0, 2'd0, 0, 1);
        step(8'h77, 1, 0, 32'hB4B3B255, 4'h0, 0, 2'd0, 0, 0);

        // Relock, then reset mid-frame at slot 2.
        step(8'h01, 1, 1, BUF ? 32'hB4B3B255 : 32'hB4B3B201, BUF ? 4'h0 : 4'b0001, 0, 2'd1, 1, 0);
        step(8'h02, 1, 0, BUF ? 32'hB4B3B255 : 32'hB4B30201, BUF ? 4'h0 : 4'b0010, 0, 2'd2, 1, 0);
        @(negedge clk);
        din_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk_all(zero, "async_rst");
        @(negedge clk);
        rst = 1'b0;

        step(8'h03, 1, 0, 32'h0, 4'h0, 0, 2'd0, 0, 0);
        step(8'h04, 1, 0, 32'h0, 4'h0, 0, 2'd0, 0, 0);
        step(8'h10, 1, 1, BUF ? 32'h0 : 32'h00000010, BUF ? 4'h0 : 4'b0001, 0, 2'd1, 1, 0);
        step(8'h00, 0, 0, BUF ? 32'h0 : 32'h00000010, 4'h0, 0, 2'd1, 1, 0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
